// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator. Divides clk down to the pixel rate, walks an
// h/v counter pair over the full raster, and registers the decoded pixel
// coordinates, visible-area flag and strobes. The sync/blank strobes pass
// through a short delay line so they line up with the drawers' registered
// r/g/b outputs.
//
// Ports:
//   clk             in   system clock (50 MHz)
//   reset           in   synchronous, active-high reset
//   x               out  pixel column, 0 outside the visible area
//   y               out  pixel row, 0 outside the visible area
//   display_enabled out  (x, y) is inside the visible area
//   pixel_tick      out  one-clk strobe per pixel period
//   frame_start     out  one-clk pulse as the raster wraps to (0,0)
//   vga_clk         out  pixel clock to the DAC, rising mid-pixel
//   vga_hs          out  hsync, active low, delayed PIPE_DELAY clks
//   vga_vs          out  vsync, active low, delayed PIPE_DELAY clks
//   vga_blank_n     out  display_enabled delayed PIPE_DELAY clks
//   vga_sync_n      out  held low (no sync-on-green)

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       display_enabled,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          tick;
  logic          hs_raw;
  logic          vs_raw;

  assign tick       = (div == DIV_MAX);
  assign vga_sync_n = 1'b0;

  // Counters and registered decode. The decode samples the counters before
  // they advance, so coordinates trail the counters by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      div             <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      x               <= '0;
      y               <= '0;
      display_enabled <= 1'b0;
      hs_raw          <= 1'b1;
      vs_raw          <= 1'b1;
      pixel_tick      <= 1'b0;
      frame_start     <= 1'b0;
      vga_clk         <= 1'b0;
    end else begin
      if (tick) begin
        div <= '0;
        if (h_cnt == H_MAX) begin
          h_cnt <= '0;
          if (v_cnt == V_MAX) v_cnt <= '0;
          else                v_cnt <= v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end else begin
        div <= div + DW'(1);
      end

      display_enabled <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
      x               <= (h_cnt < H_VIS) ? 10'(h_cnt) : 10'd0;
      y               <= (v_cnt < V_VIS) ? 9'(v_cnt) : 9'd0;
      hs_raw          <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs_raw          <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      pixel_tick      <= tick;
      frame_start     <= tick && (h_cnt == H_MAX) && (v_cnt == V_MAX);
      // High for the second half of each pixel period.
      vga_clk         <= (div >= DIV_HALF);
    end
  end

  // Delay line for {hs, vs, blank_n}; sync stages reset inactive-high.
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign vga_hs      = hs_raw;
      assign vga_vs      = vs_raw;
      assign vga_blank_n = display_enabled;
    end else begin : g_dly
      logic [2:0] dly [PIPE_DELAY];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly[i] <= 3'b110;
        end else begin
          dly[0] <= {hs_raw, vs_raw, display_enabled};
          for (int i = 1; i < PIPE_DELAY; i++) dly[i] <= dly[i-1];
        end
      end

      assign {vga_hs, vga_vs, vga_blank_n} = dly[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       de;
    logic       pt;
    logic       fs;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       bn;
  } obs_t;

  localparam obs_t RST_OBS = '{x: 10'd0, y: 9'd0, de: 1'b0, pt: 1'b0, fs: 1'b0,
                               vclk: 1'b0, hs: 1'b1, vs: 1'b1, bn: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_main;
  logic rst_small;

  // instance 0: defaults (PIPE_DELAY=1), 1: PIPE_DELAY=0, 2: PIPE_DELAY=3,
  // 3: small raster, CLK_DIV=4, PIPE_DELAY=2
  logic [9:0] x_a   [4];
  logic [8:0] y_a   [4];
  logic       de_a  [4];
  logic       pt_a  [4];
  logic       fs_a  [4];
  logic       vclk_a[4];
  logic       hs_a  [4];
  logic       vs_a  [4];
  logic       bn_a  [4];
  logic       sn_a  [4];

  vga_timing_gen #(.PIPE_DELAY(1)) u_def (
    .clk(clk), .reset(rst_main), .x(x_a[0]), .y(y_a[0]), .display_enabled(de_a[0]),
    .pixel_tick(pt_a[0]), .frame_start(fs_a[0]), .vga_clk(vclk_a[0]), .vga_hs(hs_a[0]),
    .vga_vs(vs_a[0]), .vga_blank_n(bn_a[0]), .vga_sync_n(sn_a[0]));

  vga_timing_gen #(.PIPE_DELAY(0)) u_p0 (
    .clk(clk), .reset(rst_main), .x(x_a[1]), .y(y_a[1]), .display_enabled(de_a[1]),
    .pixel_tick(pt_a[1]), .frame_start(fs_a[1]), .vga_clk(vclk_a[1]), .vga_hs(hs_a[1]),
    .vga_vs(vs_a[1]), .vga_blank_n(bn_a[1]), .vga_sync_n(sn_a[1]));

  vga_timing_gen #(.PIPE_DELAY(3)) u_p3 (
    .clk(clk), .reset(rst_main), .x(x_a[2]), .y(y_a[2]), .display_enabled(de_a[2]),
    .pixel_tick(pt_a[2]), .frame_start(fs_a[2]), .vga_clk(vclk_a[2]), .vga_hs(hs_a[2]),
    .vga_vs(vs_a[2]), .vga_blank_n(bn_a[2]), .vga_sync_n(sn_a[2]));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(4), .PIPE_DELAY(2)
  ) u_small (
    .clk(clk), .reset(rst_small), .x(x_a[3]), .y(y_a[3]), .display_enabled(de_a[3]),
    .pixel_tick(pt_a[3]), .frame_start(fs_a[3]), .vga_clk(vclk_a[3]), .vga_hs(hs_a[3]),
    .vga_vs(vs_a[3]), .vga_blank_n(bn_a[3]), .vga_sync_n(sn_a[3]));

  int tests = 0;
  int fails = 0;
  int cyc_m = 0;
  int cyc_s = 0;

  // Clocks since reset release: 1 after the first edge with reset low.
  always @(posedge clk) begin
    cyc_m <= rst_main  ? 0 : cyc_m + 1;
    cyc_s <= rst_small ? 0 : cyc_s + 1;
  end

  function automatic int pd_of(int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t o;
    o.x = x_a[i]; o.y = y_a[i]; o.de = de_a[i]; o.pt = pt_a[i]; o.fs = fs_a[i];
    o.vclk = vclk_a[i]; o.hs = hs_a[i]; o.vs = vs_a[i]; o.bn = bn_a[i];
    return o;
  endfunction

  // Closed-form raster model: outputs seen k clks after reset release (k>=1).
  function automatic obs_t model(int i, int k);
    obs_t o;
    int ha, hf, hsw, hb, va, vf, vsw, vb, cd, pd, ht, vt, p, h, v, kd;
    if (i == 3) begin
      ha = 8; hf = 2; hsw = 2; hb = 2; va = 4; vf = 1; vsw = 1; vb = 1; cd = 4;
    end else begin
      ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; cd = 2;
    end
    pd = pd_of(i);
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p = (k - 1) / cd;
    h = p % ht;
    v = (p / ht) % vt;
    o.x    = (h < ha) ? 10'(h) : 10'd0;
    o.y    = (v < va) ? 9'(v) : 9'd0;
    o.de   = (h < ha) && (v < va);
    o.pt   = ((k - 1) % cd) == cd - 1;
    o.fs   = o.pt && (h == ht - 1) && (v == vt - 1);
    o.vclk = ((k - 1) % cd) >= cd / 2;
    kd = k - pd;
    if (kd < 1) begin
      o.hs = 1'b1; o.vs = 1'b1; o.bn = 1'b0;
    end else begin
      p = (kd - 1) / cd;
      h = p % ht;
      v = (p / ht) % vt;
      o.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
      o.vs = !((v >= va + vf) && (v < va + vf + vsw));
      o.bn = (h < ha) && (v < va);
    end
    return o;
  endfunction

  // measurements collected during the sweep
  int de_cnt_l2, hs_fall, hs_rise, x_2880, x_2881;
  int de_fall[4], de_rise[4], bn_fall[4], bn_rise[4];
  int fs_cnt_s, fs_first_s, fs_second_s, vs_fall_s, vs_rise_s, hs_fall_s1, hs_fall_s2;

  task automatic test_reset();
    rst_main  = 1'b1;
    rst_small = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (get_obs(i) !== RST_OBS) begin
          fails++;
          $display("FAIL reset_values inst%0d: got %h expected %h", i, get_obs(i), RST_OBS);
        end
        tests++;
        if (sn_a[i] !== 1'b0) begin
          fails++;
          $display("FAIL reset_sync_n inst%0d: got %b expected 0", i, sn_a[i]);
        end
      end
    end
    rst_main  = 1'b0;
    rst_small = 1'b0;
  endtask

  task automatic test_startup();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({x_a[i], y_a[i], de_a[i], fs_a[i], sn_a[i]} !== {10'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL startup_origin inst%0d: got x=%0d y=%0d de=%b fs=%b sn=%b expected 0 0 1 0 0",
                 i, x_a[i], y_a[i], de_a[i], fs_a[i], sn_a[i]);
      end
    end
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk); #1;
      tests++;
      if ({pt_a[0], vclk_a[0]} !== {(k % 2 == 0), (k % 2 == 0)}) begin
        fails++;
        $display("FAIL startup_tick_def clk%0d: got pt=%b vclk=%b expected %b", k, pt_a[0], vclk_a[0], (k % 2 == 0));
      end
      tests++;
      if ({pt_a[3], vclk_a[3]} !== {(k % 4 == 0), (k % 4 == 0 || k % 4 == 3)}) begin
        fails++;
        $display("FAIL startup_tick_small clk%0d: got pt=%b vclk=%b", k, pt_a[3], vclk_a[3]);
      end
    end
  endtask

  task automatic test_sweep();
    obs_t prev[4];
    obs_t cur, exp;
    bit   dead[4];
    de_cnt_l2 = 0; hs_fall = -1; hs_rise = -1; x_2880 = -1; x_2881 = -1;
    fs_cnt_s = 0; fs_first_s = -1; fs_second_s = -1; vs_fall_s = -1; vs_rise_s = -1;
    hs_fall_s1 = -1; hs_fall_s2 = -1;
    for (int i = 0; i < 4; i++) begin
      prev[i] = get_obs(i);
      dead[i] = 1'b0;
      de_fall[i] = -1; de_rise[i] = -1; bn_fall[i] = -1; bn_rise[i] = -1;
    end
    while (cyc_m < 3300) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        cur = get_obs(i);
        if (!dead[i]) begin
          exp = model(i, cyc_m);
          tests++;
          if (cur !== exp) begin
            fails++;
            dead[i] = 1'b1;
            $display("FAIL raster_model inst%0d clk%0d: got %h expected %h", i, cyc_m, cur, exp);
          end
        end
        if (prev[i].de && !cur.de && de_fall[i] < 0) de_fall[i] = cyc_m;
        if (!prev[i].de && cur.de && de_rise[i] < 0) de_rise[i] = cyc_m;
        if (prev[i].bn && !cur.bn && bn_fall[i] < 0) bn_fall[i] = cyc_m;
        if (!prev[i].bn && cur.bn && bn_rise[i] < 0) bn_rise[i] = cyc_m;
        prev[i] = cur;
      end
      if (cyc_m >= 1601 && cyc_m <= 3200 && de_a[0]) de_cnt_l2++;
      if (cyc_m == 2880) x_2880 = int'(x_a[0]);
      if (cyc_m == 2881) x_2881 = int'(x_a[0]);
      if (hs_fall < 0 && !hs_a[0]) hs_fall = cyc_m;
      if (hs_fall >= 0 && hs_rise < 0 && hs_a[0]) hs_rise = cyc_m;
      if (fs_a[3]) begin
        fs_cnt_s++;
        if (fs_first_s < 0) fs_first_s = cyc_m;
        else if (fs_second_s < 0) fs_second_s = cyc_m;
      end
      if (vs_fall_s < 0 && !vs_a[3]) vs_fall_s = cyc_m;
      if (vs_fall_s >= 0 && vs_rise_s < 0 && vs_a[3]) vs_rise_s = cyc_m;
      if (!hs_a[3] && hs_fall_s1 < 0) hs_fall_s1 = cyc_m;
      else if (!hs_a[3] && hs_fall_s2 < 0 && cyc_m > hs_fall_s1 + 8) hs_fall_s2 = cyc_m;
    end
  endtask

  task automatic test_line_timing();
    tests++;
    if (de_cnt_l2 !== 1280) begin
      fails++; $display("FAIL line_de_width: got %0d expected 1280", de_cnt_l2);
    end
    tests++;
    if (hs_fall !== 1314) begin
      fails++; $display("FAIL line_hs_fall: got %0d expected 1314", hs_fall);
    end
    tests++;
    if (hs_rise - hs_fall !== 192) begin
      fails++; $display("FAIL line_hs_width: got %0d expected 192", hs_rise - hs_fall);
    end
    tests++;
    if ({x_2880, x_2881} !== {32'd639, 32'd0}) begin
      fails++; $display("FAIL line_x_end: got %0d,%0d expected 639,0", x_2880, x_2881);
    end
  endtask

  task automatic test_alignment();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({de_fall[i], de_rise[i]} !== {32'd1281, 32'd1601}) begin
        fails++; $display("FAIL align_de_edges inst%0d: got %0d,%0d expected 1281,1601", i, de_fall[i], de_rise[i]);
      end
      tests++;
      if ({bn_fall[i] - de_fall[i], bn_rise[i] - de_rise[i]} !== {pd_of(i), pd_of(i)}) begin
        fails++;
        $display("FAIL align_blank inst%0d: got lag %0d,%0d expected %0d", i,
                 bn_fall[i] - de_fall[i], bn_rise[i] - de_rise[i], pd_of(i));
      end
    end
  endtask

  task automatic test_small_frame();
    tests++;
    if ({fs_cnt_s, fs_first_s, fs_second_s} !== {32'd8, 32'd392, 32'd784}) begin
      fails++; $display("FAIL small_frame_start: got n=%0d at %0d,%0d expected 8 at 392,784",
                        fs_cnt_s, fs_first_s, fs_second_s);
    end
    tests++;
    if ({vs_fall_s, vs_rise_s} !== {32'd283, 32'd339}) begin
      fails++; $display("FAIL small_vsync: got %0d..%0d expected 283..339", vs_fall_s, vs_rise_s);
    end
    tests++;
    if ({hs_fall_s1, hs_fall_s2} !== {32'd43, 32'd99}) begin
      fails++; $display("FAIL small_line_period: got hs falls %0d,%0d expected 43,99", hs_fall_s1, hs_fall_s2);
    end
  endtask

  task automatic test_midframe_reset();
    int   budget = 0;
    int   fs_seen = 0;
    obs_t cur, exp;
    while (!(x_a[3] == 10'd5 && y_a[3] == 9'd2) && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    tests++;
    if (budget >= 500) begin
      fails++; $display("FAIL midreset_find: got no x=5,y=2 within 500 clk expected one");
    end
    rst_small = 1'b1;
    @(posedge clk); #1;
    rst_small = 1'b0;
    tests++;
    if (get_obs(3) !== RST_OBS) begin
      fails++; $display("FAIL midreset_values: got %h expected %h", get_obs(3), RST_OBS);
    end
    @(posedge clk); #1;
    tests++;
    if ({x_a[3], y_a[3], de_a[3]} !== {10'd0, 9'd0, 1'b1}) begin
      fails++; $display("FAIL midreset_origin: got x=%0d y=%0d de=%b expected 0 0 1", x_a[3], y_a[3], de_a[3]);
    end
    while (cyc_s < 392) begin
      @(posedge clk); #1;
      if (fs_a[3] && cyc_s < 392) fs_seen++;
      cur = get_obs(3);
      exp = model(3, cyc_s);
      tests++;
      if (cur !== exp) begin
        fails++; $display("FAIL midreset_model clk%0d: got %h expected %h", cyc_s, cur, exp);
      end
    end
    tests++;
    if ({fs_seen, 31'd0, fs_a[3]} !== {32'd0, 32'd1}) begin
      fails++; $display("FAIL midreset_no_frame_start: got early=%0d at392=%b expected 0,1", fs_seen, fs_a[3]);
    end
  endtask

  initial begin
    rst_main  = 1'b1;
    rst_small = 1'b1;
    test_reset();
    test_startup();
    test_sweep();
    test_line_timing();
    test_alignment();
    test_small_frame();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
